// File: rtl/ifetch_stream_pkg.sv
// Shared types and decode helpers for the instruction-fetch stream buffer.
// A stored entry is one fetched 32-bit word together with its bus-error flag.
package ifetch_stream_pkg;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } fetch_entry_t;

    // A halfword starts a compressed instruction unless its two low bits are 2'b11.
    function automatic logic is_compressed(input logic [1:0] lsbs);
        return (lsbs != 2'b11);
    endfunction

endpackage

// File: rtl/ifetch_stream_align.sv
// Combinational aligner: builds one instruction from the two oldest FIFO words.
// The instruction is built according to addr[1] and to the compressed/uncompressed decode.
module ifetch_stream_align
    import ifetch_stream_pkg::*;
(
    input  logic        addr_hi_i,
    input  logic        e0_valid_i,
    input  logic [31:0] e0_rdata_i,
    input  logic        e0_err_i,
    input  logic        e1_valid_i,
    input  logic [15:0] e1_half_i,
    input  logic        e1_err_i,
    output logic        valid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        err_plus2_o,
    output logic        size4_o
);

    logic uncomp_s;

    // Select and merge halfwords; an unaligned 32-bit instruction straddles two words.
    always_comb begin
        valid_o     = 1'b0;
        rdata_o     = 32'd0;
        err_o       = 1'b0;
        err_plus2_o = 1'b0;
        uncomp_s    = 1'b0;
        if (!addr_hi_i) begin
            uncomp_s = ~is_compressed(e0_rdata_i[1:0]);
            valid_o  = e0_valid_i;
            rdata_o  = e0_rdata_i;
            err_o    = e0_err_i;
        end else begin
            uncomp_s = ~is_compressed(e0_rdata_i[17:16]);
            rdata_o  = {e1_half_i, e0_rdata_i[31:16]};
            if (uncomp_s) begin
                // An error on the first half makes the instruction presentable on its own.
                valid_o     = e0_valid_i & (e1_valid_i | e0_err_i);
                err_o       = e0_err_i | (e1_valid_i & e1_err_i);
                err_plus2_o = ~e0_err_i & e1_valid_i & e1_err_i;
            end else begin
                valid_o     = e0_valid_i;
                err_o       = e0_err_i;
                err_plus2_o = 1'b0;
            end
        end
        size4_o = uncomp_s;
    end

endmodule

// File: rtl/ifetch_stream_buffer_chk.sv
// Protocol checker for the fetch stream buffer: a push into a full FIFO
// needs a simultaneous pop, otherwise the incoming word is lost.
module ifetch_stream_buffer_chk (
    input  logic clk_i,
    input  logic rst_i,
    input  logic in_valid_i,
    input  logic clear_i,
    input  logic full_i,
    input  logic pop_i
);

    a_no_push_when_full: assert property (
        @(posedge clk_i) disable iff (rst_i)
        (in_valid_i && !clear_i && full_i) |-> pop_i
    );

endmodule

// File: rtl/ifetch_stream_buffer.sv
// Instruction-fetch stream buffer: in-order FIFO of fetched words feeding a
// halfword-granular instruction stream that handles compressed instructions.
module ifetch_stream_buffer
    import ifetch_stream_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic [31:0] clear_addr_i,
    input  logic        in_valid_i,
    input  logic [31:0] in_rdata_i,
    input  logic        in_err_i,
    output logic        busy_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_addr_o,
    output logic [31:0] out_rdata_o,
    output logic        out_err_o,
    output logic        out_err_plus2_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      addr_q, addr_d;
    logic [CNT_W-1:0] wr_idx_s;
    logic             full_s, push_s, pop_s, handshake_s, size4_s;

    ifetch_stream_align u_align (
        .addr_hi_i   (addr_q[1]),
        .e0_valid_i  (count_q != {CNT_W{1'b0}}),
        .e0_rdata_i  (mem_q[0].rdata),
        .e0_err_i    (mem_q[0].err),
        .e1_valid_i  (count_q > CNT_W'(1)),
        .e1_half_i   (mem_q[1].rdata[15:0]),
        .e1_err_i    (mem_q[1].err),
        .valid_o     (out_valid_o),
        .rdata_o     (out_rdata_o),
        .err_o       (out_err_o),
        .err_plus2_o (out_err_plus2_o),
        .size4_o     (size4_s)
    );

    // Handshake and FIFO control; an aligned compressed instruction leaves its word in place.
    always_comb begin
        full_s      = (count_q == CNT_W'(DEPTH));
        handshake_s = out_valid_o & out_ready_i & ~clear_i;
        pop_s       = handshake_s & (addr_q[1] | size4_s);
        push_s      = in_valid_i & ~clear_i & (~full_s | pop_s);
        wr_idx_s    = count_q - CNT_W'(pop_s);
        busy_o      = (count_q >= CNT_W'(DEPTH - 1));
    end

    // Next-state: shift out the oldest word on pop, write the new word behind the survivors.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            if (push_s && (CNT_W'(i) == wr_idx_s)) begin
                mem_d[i] = '{rdata: in_rdata_i, err: in_err_i};
            end else if (pop_s && (i < DEPTH - 1)) begin
                mem_d[i] = mem_q[(i < DEPTH - 1) ? i + 1 : i];
            end else begin
                mem_d[i] = mem_q[i];
            end
        end
        if (clear_i) begin
            count_d = {CNT_W{1'b0}};
            addr_d  = clear_addr_i & ~32'd1;
        end else begin
            count_d = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
            if (handshake_s) begin
                addr_d = addr_q + (size4_s ? 32'd4 : 32'd2);
            end else begin
                addr_d = addr_q;
            end
        end
    end

    // State registers with asynchronous reset to an empty buffer at address 0.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= {CNT_W{1'b0}};
            addr_q  <= 32'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            addr_q  <= addr_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign out_addr_o = addr_q;

    ifetch_stream_buffer_chk u_chk (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .in_valid_i (in_valid_i),
        .clear_i    (clear_i),
        .full_i     (full_s),
        .pop_i      (pop_s)
    );

endmodule

// File: tb/tb_ifetch_stream_buffer.sv
// Directed self-checking bench for ifetch_stream_buffer (DEPTH=3).
// Each step drives inputs just after a rising edge and checks the settled outputs.
module tb_ifetch_stream_buffer;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        clear_i = 1'b0;
    logic [31:0] clear_addr_i = 32'd0;
    logic        in_valid_i = 1'b0;
    logic [31:0] in_rdata_i = 32'd0;
    logic        in_err_i = 1'b0;
    logic        busy_o;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [31:0] out_addr_o;
    logic [31:0] out_rdata_o;
    logic        out_err_o;
    logic        out_err_plus2_o;

    int n_cmp = 0;
    int n_mis = 0;

    ifetch_stream_buffer #(.DEPTH(3)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .clear_i         (clear_i),
        .clear_addr_i    (clear_addr_i),
        .in_valid_i      (in_valid_i),
        .in_rdata_i      (in_rdata_i),
        .in_err_i        (in_err_i),
        .busy_o          (busy_o),
        .out_valid_o     (out_valid_o),
        .out_ready_i     (out_ready_i),
        .out_addr_o      (out_addr_o),
        .out_rdata_o     (out_rdata_o),
        .out_err_o       (out_err_o),
        .out_err_plus2_o (out_err_plus2_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_clear(input logic [31:0] addr);
        clear_i      = 1'b1;
        clear_addr_i = addr;
        tick();
        clear_i      = 1'b0;
    endtask

    task automatic push(input logic [31:0] word, input logic err);
        in_valid_i = 1'b1;
        in_rdata_i = word;
        in_err_i   = err;
        tick();
        in_valid_i = 1'b0;
        in_err_i   = 1'b0;
    endtask

    initial begin
        #1;
        check_eq("rst_addr",  out_addr_o, 32'd0);
        check_eq("rst_valid", {31'd0, out_valid_o}, 32'd0);
        check_eq("rst_err",   {31'd0, out_err_o}, 32'd0);
        check_eq("rst_plus2", {31'd0, out_err_plus2_o}, 32'd0);
        check_eq("rst_busy",  {31'd0, busy_o}, 32'd0);
        tick();
        tick();
        rst_i = 1'b0;

        // Aligned uncompressed word consumed immediately
        out_ready_i = 1'b1;
        do_clear(32'h0000_0100);
        check_eq("a_clr_addr",  out_addr_o, 32'h0000_0100);
        check_eq("a_clr_valid", {31'd0, out_valid_o}, 32'd0);
        push(32'h0000_0013, 1'b0);
        check_eq("a_valid", {31'd0, out_valid_o}, 32'd1);
        check_eq("a_addr",  out_addr_o, 32'h0000_0100);
        check_eq("a_rdata", out_rdata_o, 32'h0000_0013);
        check_eq("a_err",   {31'd0, out_err_o}, 32'd0);
        tick();
        check_eq("a_empty", {31'd0, out_valid_o}, 32'd0);
        check_eq("a_next",  out_addr_o, 32'h0000_0104);

        // Unaligned compressed from the upper half
        out_ready_i = 1'b0;
        do_clear(32'h0000_0102);
        push(32'h4501_4501, 1'b0);
        check_eq("b_valid", {31'd0, out_valid_o}, 32'd1);
        check_eq("b_addr",  out_addr_o, 32'h0000_0102);
        check_eq("b_rdata", {16'd0, out_rdata_o[15:0]}, 32'h0000_4501);
        out_ready_i = 1'b1;
        tick();
        check_eq("b_next",  out_addr_o, 32'h0000_0104);
        check_eq("b_empty", {31'd0, out_valid_o}, 32'd0);

        // Unaligned uncompressed waits for its second word
        out_ready_i = 1'b0;
        do_clear(32'h0000_0102);
        push(32'h0013_0000, 1'b0);
        check_eq("c_wait", {31'd0, out_valid_o}, 32'd0);
        push(32'h0000_0000, 1'b0);
        check_eq("c_valid", {31'd0, out_valid_o}, 32'd1);
        check_eq("c_rdata", out_rdata_o, 32'h0000_0013);
        check_eq("c_err",   {31'd0, out_err_o}, 32'd0);
        check_eq("c_plus2", {31'd0, out_err_plus2_o}, 32'd0);
        out_ready_i = 1'b1;
        tick();
        check_eq("c_addr1",  out_addr_o, 32'h0000_0106);
        check_eq("c_valid1", {31'd0, out_valid_o}, 32'd1);
        check_eq("c_rdata1", {16'd0, out_rdata_o[15:0]}, 32'h0000_0000);
        tick();
        check_eq("c_addr2",  out_addr_o, 32'h0000_0108);
        check_eq("c_empty",  {31'd0, out_valid_o}, 32'd0);

        // Error only on the second halfword
        out_ready_i = 1'b0;
        do_clear(32'h0000_0102);
        push(32'h0003_0000, 1'b0);
        push(32'hDEAD_BEEF, 1'b1);
        check_eq("d_valid", {31'd0, out_valid_o}, 32'd1);
        check_eq("d_rdata", out_rdata_o, 32'hBEEF_0003);
        check_eq("d_err",   {31'd0, out_err_o}, 32'd1);
        check_eq("d_plus2", {31'd0, out_err_plus2_o}, 32'd1);

        // Fill to full, then push and pop together, then drain
        do_clear(32'h0000_0100);
        push(32'h0000_0013, 1'b0);
        check_eq("e_busy1", {31'd0, busy_o}, 32'd0);
        push(32'h0010_0093, 1'b0);
        check_eq("e_busy2", {31'd0, busy_o}, 32'd1);
        push(32'h0020_0113, 1'b0);
        check_eq("e_busy3", {31'd0, busy_o}, 32'd1);
        check_eq("e_head",  out_rdata_o, 32'h0000_0013);
        out_ready_i = 1'b1;
        push(32'h0030_0193, 1'b0);
        check_eq("e_pp_busy",  {31'd0, busy_o}, 32'd1);
        check_eq("e_pp_addr",  out_addr_o, 32'h0000_0104);
        check_eq("e_pp_rdata", out_rdata_o, 32'h0010_0093);
        tick();
        check_eq("e_dr_addr1",  out_addr_o, 32'h0000_0108);
        check_eq("e_dr_rdata1", out_rdata_o, 32'h0020_0113);
        tick();
        check_eq("e_dr_addr2",  out_addr_o, 32'h0000_010C);
        check_eq("e_dr_rdata2", out_rdata_o, 32'h0030_0193);
        tick();
        check_eq("e_dr_addr3",  out_addr_o, 32'h0000_0110);
        check_eq("e_dr_empty",  {31'd0, out_valid_o}, 32'd0);

        // Aligned error and address wrap-around
        out_ready_i = 1'b0;
        do_clear(32'hFFFF_FFFC);
        push(32'h0000_0013, 1'b1);
        check_eq("f_valid", {31'd0, out_valid_o}, 32'd1);
        check_eq("f_err",   {31'd0, out_err_o}, 32'd1);
        check_eq("f_plus2", {31'd0, out_err_plus2_o}, 32'd0);
        out_ready_i = 1'b1;
        tick();
        check_eq("f_wrap",  out_addr_o, 32'h0000_0000);
        check_eq("f_empty", {31'd0, out_valid_o}, 32'd0);

        // Push in the clear cycle is dropped; odd clear address is forced even
        out_ready_i  = 1'b0;
        clear_i      = 1'b1;
        clear_addr_i = 32'h0000_0201;
        in_valid_i   = 1'b1;
        in_rdata_i   = 32'h0000_0013;
        tick();
        clear_i    = 1'b0;
        in_valid_i = 1'b0;
        check_eq("g_drop",  {31'd0, out_valid_o}, 32'd0);
        check_eq("g_addr",  out_addr_o, 32'h0000_0200);
        push(32'h0000_0013, 1'b0);
        check_eq("g_valid", {31'd0, out_valid_o}, 32'd1);
        push(32'h0000_0093, 1'b1);
        check_eq("g_busy",  {31'd0, busy_o}, 32'd1);

        // Asynchronous reset mid-cycle
        #2;
        rst_i = 1'b1;
        #1;
        check_eq("h_addr",  out_addr_o, 32'd0);
        check_eq("h_valid", {31'd0, out_valid_o}, 32'd0);
        check_eq("h_err",   {31'd0, out_err_o}, 32'd0);
        check_eq("h_plus2", {31'd0, out_err_plus2_o}, 32'd0);
        check_eq("h_busy",  {31'd0, busy_o}, 32'd0);
        check_eq("h_rdata", out_rdata_o, 32'd0);
        tick();
        rst_i = 1'b0;
        tick();
        check_eq("h_post_valid", {31'd0, out_valid_o}, 32'd0);
        check_eq("h_post_addr",  out_addr_o, 32'd0);
        check_eq("h_post_busy",  {31'd0, busy_o}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
